game_input_conditioner: RTL and testbench

Front-end stage feeding the game state machine. Turns the raw asynchronous push-button into a clean single-cycle `button_press` pulse using a synchroniser, a debounce FSM and a counter. Turns the level-held USB keycode (written by software, held while the key is down) into single-cycle key events, including a dedicated Enter strobe that starts level 1 from the menu. Outputs connect directly to the FSM's `button_press` and keycode-event inputs.

---
 rtl/game_input_conditioner.sv | 163 ++++++++++++++++
 tb/tb_game_input_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_input_conditioner.sv
// Input front-end for the game FSM: turns the raw push-button into a debounced
// level plus a single press pulse, and turns the level-held USB keycode into
// single-cycle key events with a dedicated Enter strobe.
module game_input_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_W           = 20,
  parameter logic [7:0]  ENTER_CODE      = 8'h28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button_raw,
  input  logic [7:0]  keycode,
  output logic        button_press,
  output logic        button_level,
  output logic        key_event,
  output logic [7:0]  key_code,
  output logic        enter_press,
  output logic [31:0] debugging
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Handshake note: there is no valid/ready flow control here; every output
  // is a registered level or a one-cycle strobe that the consumer must sample
  // on the cycle it is high.

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;

  logic [7:0]       kc_q;
  logic             armed_q, armed_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_event_q, key_event_d;
  logic             enter_q, enter_d;
  logic             kc_stable, kc_accept;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  // Saturating counter increment; the count never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Debounce FSM next state: any state change clears the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // Debounce FSM registers; reset abandons any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Key acceptance: a code is stable once it matches last cycle's sample; a
  // stable code different from the last accepted one counts as a re-arm so
  // roll-over between keys produces an event without an intervening release.
  assign kc_stable = (keycode == kc_q);
  assign kc_accept = kc_stable && (keycode != 8'h00) &&
                     (armed_q || (keycode != key_code_q));

  // Key path next-state values.
  always_comb begin
    armed_d     = armed_q;
    key_code_d  = key_code_q;
    key_event_d = 1'b0;
    enter_d     = 1'b0;
    if (kc_accept) begin
      armed_d     = 1'b0;
      key_code_d  = keycode;
      key_event_d = 1'b1;
      enter_d     = (keycode == ENTER_CODE);
    end else if (kc_stable && (keycode == 8'h00)) begin
      armed_d = 1'b1;
    end
  end

  // Key path registers; armed out of reset so the first key is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q        <= 8'h00;
      armed_q     <= 1'b1;
      key_code_q  <= 8'h00;
      key_event_q <= 1'b0;
      enter_q     <= 1'b0;
    end else begin
      kc_q        <= keycode;
      armed_q     <= armed_d;
      key_code_q  <= key_code_d;
      key_event_q <= key_event_d;
      enter_q     <= enter_d;
    end
  end

  assign button_press = press_q;
  assign button_level = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign key_event    = key_event_q;
  assign key_code     = key_code_q;
  assign enter_press  = enter_q;
  assign debugging    = {armed_q, 20'(cnt_q), key_code_q, sync2_q, state_q};

endmodule

// File: tb/tb_game_input_conditioner.sv
// Bench for game_input_conditioner: directed scenarios followed by random
// button/key activity, every cycle compared against a behavioural model.
module tb_game_input_conditioner;

  localparam int         D     = 4;
  localparam logic [7:0] ENTER = 8'h28;

  logic        clk = 1'b0;
  logic        reset;
  logic        button_raw;
  logic [7:0]  keycode;
  logic        button_press, button_level, key_event, enter_press;
  logic [7:0]  key_code;
  logic [31:0] debugging;

  int checks   = 0;
  int failures = 0;

  // Model state: button seen through a two-sample delay line, a run length of
  // samples disagreeing with the accepted level, and the key acceptance rules.
  logic       m_dly[$];
  logic       m_level, m_press;
  int         m_run;
  logic [7:0] m_prev, m_code;
  logic       m_armed, m_event, m_enter, m_btn_s;

  // Observed-event bookkeeping for the directed scenarios.
  int         n_press, n_key;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  game_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .CNT_W(4), .ENTER_CODE(ENTER)
  ) dut (
    .clk(clk), .reset(reset), .button_raw(button_raw), .keycode(keycode),
    .button_press(button_press), .button_level(button_level),
    .key_event(key_event), .key_code(key_code), .enter_press(enter_press),
    .debugging(debugging)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dly   = '{1'b0, 1'b0};
    m_level = 1'b0; m_press = 1'b0; m_run = 0; m_btn_s = 1'b0;
    m_prev  = 8'h00; m_code = 8'h00; m_armed = 1'b1;
    m_event = 1'b0; m_enter = 1'b0;
  endtask

  // One clock of the model, using the inputs applied before the edge.
  task automatic model_clock();
    logic seen;
    if (reset) begin
      model_reset();
      return;
    end
    seen = m_dly.pop_front();
    m_dly.push_back(button_raw);
    m_btn_s = m_dly[0];
    m_press = 1'b0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = seen;
        m_press = seen;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_event = 1'b0;
    m_enter = 1'b0;
    if (keycode == m_prev) begin
      if (keycode == 8'h00) m_armed = 1'b1;
      else if (m_armed || keycode != m_code) begin
        m_event = 1'b1;
        m_enter = (keycode == ENTER);
        m_code  = keycode;
        m_armed = 1'b0;
      end
    end
    m_prev = keycode;
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic step(input logic rst, input logic raw, input logic [7:0] kc);
    reset = rst; button_raw = raw; keycode = kc;
    @(posedge clk);
    model_clock();
    #1;
    check_val("button_press", button_press, m_press);
    check_val("button_level", button_level, m_level);
    check_val("key_event",    key_event,    m_event);
    check_val("enter_press",  enter_press,  m_enter);
    check_val("key_code",     key_code,     m_code);
    check_val("dbg_btn_s",    debugging[2], m_btn_s);
    check_val("dbg_key_code", debugging[10:3], m_code);
    check_val("dbg_armed",    debugging[31], m_armed);
    if (button_press) n_press++;
    if (key_event) got_q.push_back({enter_press, key_code});
    if (key_event) n_key++;
  endtask

  // Hold inputs for n cycles; returns the first cycle index (1-based) that
  // showed a press pulse, or -1.
  task automatic hold(input int n, input logic raw, input logic [7:0] kc, output int first_press);
    first_press = -1;
    for (int i = 1; i <= n; i++) begin
      step(1'b0, raw, kc);
      if (button_press && first_press < 0) first_press = i;
    end
  endtask

  initial begin
    int fp;
    int seg_b, seg_k;
    logic raw_r;
    logic [7:0] kc_r;
    logic [7:0] codes[4];
    codes = '{8'h00, 8'h04, 8'h28, 8'h16};
    model_reset();

    // Reset with button and Enter held: outputs stay low.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, ENTER);
      check_val("rst_outputs", {button_press, button_level, key_event, enter_press, key_code}, 12'h0);
      check_val("rst_debug", debugging, 32'h8000_0000);
    end
    n_press = 0; n_key = 0;
    step(1'b0, 1'b1, ENTER);
    step(1'b0, 1'b1, ENTER);
    check_val("enter_after_reset", enter_press, 1'b1);
    hold(10, 1'b1, ENTER, fp);
    check_val("press_latency_reset", fp, 2 + D + 1 - 2);
    check_val("press_count_reset", n_press, 1);

    // Release, then bounce 1,0,1,0 every 2 cycles, then stable high.
    hold(20, 1'b0, 8'h00, fp);
    n_press = 0;
    for (int b = 0; b < 4; b++) hold(2, ~b[0], 8'h00, fp);
    hold(10, 1'b1, 8'h00, fp);
    check_val("bounce_press_latency", fp, 2 + D + 1);
    check_val("bounce_press_count", n_press, 1);
    check_val("bounce_level", button_level, 1'b1);

    // Long hold, release with a 2-cycle bounce, stay low.
    hold(50, 1'b1, 8'h00, fp);
    hold(1, 1'b0, 8'h00, fp);
    hold(2, 1'b1, 8'h00, fp);
    hold(10, 1'b0, 8'h00, fp);
    check_val("hold_press_count", n_press, 1);
    check_val("hold_level_low", button_level, 1'b0);

    // Key sequence 00 -> 28 (20 cycles) -> 00 -> 04.
    got_q.delete(); exp_q.delete();
    exp_q.push_back({1'b1, 8'h28});
    exp_q.push_back({1'b0, 8'h04});
    hold(3, 1'b0, 8'h00, fp);
    hold(20, 1'b0, 8'h28, fp);
    hold(4, 1'b0, 8'h00, fp);
    hold(6, 1'b0, 8'h04, fp);
    // Glitch then roll-over 04 -> 16.
    hold(3, 1'b0, 8'h00, fp);
    hold(1, 1'b0, 8'h1A, fp);
    hold(4, 1'b0, 8'h00, fp);
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b0, 8'h16});
    hold(5, 1'b0, 8'h04, fp);
    hold(5, 1'b0, 8'h16, fp);
    check_val("key_event_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_val("key_event_value", got_q.pop_front(), exp_q.pop_front());

    // Mid-debounce reset: counter at 2, one reset cycle with button high.
    hold(5, 1'b1, 8'h00, fp);
    n_press = 0;
    step(1'b1, 1'b1, 8'h00);
    check_val("midrst_no_pulse", button_press, 1'b0);
    hold(12, 1'b1, 8'h00, fp);
    check_val("midrst_press_latency", fp, 2 + D + 1);
    check_val("midrst_press_count", n_press, 1);

    // Random activity on both paths with occasional resets.
    seg_b = 0; seg_k = 0; raw_r = 1'b0; kc_r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (seg_b == 0) begin
        raw_r = 1'($urandom_range(0, 1));
        seg_b = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 3);
      end
      if (seg_k == 0) begin
        kc_r  = codes[$urandom_range(0, 3)];
        seg_k = $urandom_range(1, 6);
      end
      seg_b--; seg_k--;
      step(($urandom_range(0, 299) == 0), raw_r, kc_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
